// File: rtl/axis_conv_input_joiner.sv
// rtl/axis_conv_input_joiner.sv - joins COPIES pixel streams and one weight stream into one registered beat
// Optional copy-user consistency check enabled by defining JOINER_USER_CHECK_EN.
module axis_conv_input_joiner #(
    parameter int COPIES         = 2,
    parameter int PIX_WIDTH      = 64,
    parameter int PIX_USER_WIDTH = 8,
    parameter int W_WIDTH        = 128,
    parameter int W_USER_WIDTH   = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [COPIES-1:0]                    s_axis_pixels_tvalid,
    output logic [COPIES-1:0]                    s_axis_pixels_tready,
    input  logic [COPIES*PIX_WIDTH-1:0]          s_axis_pixels_tdata,
    input  logic [COPIES*PIX_USER_WIDTH-1:0]     s_axis_pixels_tuser,
    input  logic                                 s_axis_weights_tvalid,
    output logic                                 s_axis_weights_tready,
    input  logic                                 s_axis_weights_tlast,
    input  logic [W_WIDTH-1:0]                   s_axis_weights_tdata,
    input  logic [W_USER_WIDTH-1:0]              s_axis_weights_tuser,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic [COPIES*PIX_WIDTH-1:0]          m_axis_pixels_tdata,
    output logic [W_WIDTH-1:0]                   m_axis_weights_tdata,
    output logic [W_USER_WIDTH+PIX_USER_WIDTH-1:0] m_axis_tuser,
    output logic [CNT_WIDTH-1:0]                 beat_count,
    output logic                                 err_user_mismatch
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam int WW = W_WIDTH + W_USER_WIDTH + 1;
    localparam int UW = W_USER_WIDTH + PIX_USER_WIDTH;
`ifdef JOINER_USER_CHECK_EN
    localparam int UC = COPIES;
`else
    // Only copy 0 user travels to the output, so the other copies' users are not buffered.
    localparam int UC = 1;
`endif

    logic [PIX_WIDTH-1:0]      r_pix_mem [COPIES][FIFO_DEPTH];
    logic [PIX_USER_WIDTH-1:0] r_usr_mem [UC][FIFO_DEPTH];
    logic [AW-1:0]             r_pix_wr  [COPIES];
    logic [AW-1:0]             r_pix_rd  [COPIES];
    logic [CW-1:0]             r_pix_cnt [COPIES];
    logic [COPIES-1:0]         r_pix_tready;

    logic [WW-1:0]             r_w_mem [FIFO_DEPTH];
    logic [AW-1:0]             r_w_wr;
    logic [AW-1:0]             r_w_rd;
    logic [CW-1:0]             r_w_cnt;
    logic                      r_w_tready;

    logic                      r_m_tvalid;
    logic                      r_m_tlast;
    logic [COPIES*PIX_WIDTH-1:0] r_m_pix;
    logic [W_WIDTH-1:0]        r_m_w;
    logic [UW-1:0]             r_m_tuser;
    logic [CNT_WIDTH-1:0]      r_beat_cnt;

    logic [COPIES-1:0]         w_pix_push;
    logic [COPIES-1:0]         w_pix_nonempty;
    logic [CW-1:0]             w_pix_cnt_nxt [COPIES];
    logic [COPIES*PIX_WIDTH-1:0] w_pix_head;
    logic [PIX_USER_WIDTH-1:0] w_usr_head [UC];
    logic                      w_w_push;
    logic                      w_w_nonempty;
    logic [CW-1:0]             w_w_cnt_nxt;
    logic [WW-1:0]             w_w_head;
    logic                      w_join;
    logic                      w_out_hs;

    assign w_pix_push     = s_axis_pixels_tvalid & r_pix_tready;
    assign w_w_push       = s_axis_weights_tvalid & r_w_tready;
    assign w_w_nonempty   = (r_w_cnt != '0);
    assign w_join         = (&w_pix_nonempty) & w_w_nonempty & (~r_m_tvalid | m_axis_tready);
    assign w_out_hs       = r_m_tvalid & m_axis_tready;
    assign w_w_head       = r_w_mem[r_w_rd];

    always_comb begin
        w_pix_head = '0;
        for (int c = 0; c < COPIES; c++) begin
            w_pix_nonempty[c] = (r_pix_cnt[c] != '0);
            w_pix_head[c*PIX_WIDTH +: PIX_WIDTH] = r_pix_mem[c][r_pix_rd[c]];
            w_pix_cnt_nxt[c] = r_pix_cnt[c];
            if (w_pix_push[c] && !w_join) begin
                w_pix_cnt_nxt[c] = r_pix_cnt[c] + 1'b1;
            end else if (!w_pix_push[c] && w_join) begin
                w_pix_cnt_nxt[c] = r_pix_cnt[c] - 1'b1;
            end
        end
        for (int u = 0; u < UC; u++) begin
            w_usr_head[u] = r_usr_mem[u][r_pix_rd[u]];
        end
    end

    always_comb begin
        w_w_cnt_nxt = r_w_cnt;
        if (w_w_push && !w_join) begin
            w_w_cnt_nxt = r_w_cnt + 1'b1;
        end else if (!w_w_push && w_join) begin
            w_w_cnt_nxt = r_w_cnt - 1'b1;
        end
    end

    // Ready is registered from the next occupancy so m_axis_tready never reaches s_tready combinationally.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int c = 0; c < COPIES; c++) begin
                r_pix_wr[c]  <= '0;
                r_pix_rd[c]  <= '0;
                r_pix_cnt[c] <= '0;
            end
            r_pix_tready <= '0;
        end else begin
            for (int c = 0; c < COPIES; c++) begin
                if (w_pix_push[c]) begin
                    r_pix_wr[c] <= r_pix_wr[c] + 1'b1;
                end
                if (w_join) begin
                    r_pix_rd[c] <= r_pix_rd[c] + 1'b1;
                end
                r_pix_cnt[c]    <= w_pix_cnt_nxt[c];
                r_pix_tready[c] <= (w_pix_cnt_nxt[c] != FULL);
            end
        end
    end

    always_ff @(posedge aclk) begin
        for (int c = 0; c < COPIES; c++) begin
            if (w_pix_push[c]) begin
                r_pix_mem[c][r_pix_wr[c]] <= s_axis_pixels_tdata[c*PIX_WIDTH +: PIX_WIDTH];
            end
        end
        for (int u = 0; u < UC; u++) begin
            if (w_pix_push[u]) begin
                r_usr_mem[u][r_pix_wr[u]] <= s_axis_pixels_tuser[u*PIX_USER_WIDTH +: PIX_USER_WIDTH];
            end
        end
        if (w_w_push) begin
            r_w_mem[r_w_wr] <= {s_axis_weights_tdata, s_axis_weights_tuser, s_axis_weights_tlast};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_w_wr     <= '0;
            r_w_rd     <= '0;
            r_w_cnt    <= '0;
            r_w_tready <= 1'b0;
        end else begin
            if (w_w_push) begin
                r_w_wr <= r_w_wr + 1'b1;
            end
            if (w_join) begin
                r_w_rd <= r_w_rd + 1'b1;
            end
            r_w_cnt    <= w_w_cnt_nxt;
            r_w_tready <= (w_w_cnt_nxt != FULL);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_pix    <= '0;
            r_m_w      <= '0;
            r_m_tuser  <= '0;
        end else if (w_join) begin
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= w_w_head[0];
            r_m_pix    <= w_pix_head;
            r_m_w      <= w_w_head[WW-1 -: W_WIDTH];
            r_m_tuser  <= {w_w_head[W_USER_WIDTH:1], w_usr_head[0]};
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_beat_cnt <= '0;
        end else if (w_out_hs) begin
            if (r_m_tlast) begin
                r_beat_cnt <= '0;
            end else if (r_beat_cnt != '1) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

`ifdef JOINER_USER_CHECK_EN
    logic r_err;
    logic w_usr_mismatch;

    always_comb begin
        w_usr_mismatch = 1'b0;
        for (int u = 1; u < UC; u++) begin
            if (w_usr_head[u] != w_usr_head[0]) begin
                w_usr_mismatch = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_err <= 1'b0;
        end else if (w_join && w_usr_mismatch) begin
            r_err <= 1'b1;
        end
    end

    assign err_user_mismatch = r_err;
`else
    assign err_user_mismatch = 1'b0;

    generate
        if (COPIES > 1) begin : g_drop_user
            logic w_unused_user;
            assign w_unused_user = ^s_axis_pixels_tuser[COPIES*PIX_USER_WIDTH-1:PIX_USER_WIDTH];
        end
    endgenerate
`endif

    assign s_axis_pixels_tready  = r_pix_tready;
    assign s_axis_weights_tready = r_w_tready;
    assign m_axis_tvalid         = r_m_tvalid;
    assign m_axis_tlast          = r_m_tlast;
    assign m_axis_pixels_tdata   = r_m_pix;
    assign m_axis_weights_tdata  = r_m_w;
    assign m_axis_tuser          = r_m_tvalid ? r_m_tuser : '0;
    assign beat_count            = r_beat_cnt;

endmodule

// File: tb/tb_axis_conv_input_joiner.sv
// tb/tb_axis_conv_input_joiner.sv - randomized scoreboard bench for axis_conv_input_joiner
module tb_axis_conv_input_joiner;

    localparam int COPIES = 2;
    localparam int PW     = 64;
    localparam int PUW    = 8;
    localparam int WW     = 128;
    localparam int WUW    = 8;
    localparam int DEPTH  = 4;
    localparam int CNTW   = 16;
`ifdef JOINER_USER_CHECK_EN
    localparam bit USER_CHK = 1'b1;
`else
    localparam bit USER_CHK = 1'b0;
`endif

    logic                   aclk;
    logic                   aresetn;
    logic [COPIES-1:0]      s_axis_pixels_tvalid;
    logic [COPIES-1:0]      s_axis_pixels_tready;
    logic [COPIES*PW-1:0]   s_axis_pixels_tdata;
    logic [COPIES*PUW-1:0]  s_axis_pixels_tuser;
    logic                   s_axis_weights_tvalid;
    logic                   s_axis_weights_tready;
    logic                   s_axis_weights_tlast;
    logic [WW-1:0]          s_axis_weights_tdata;
    logic [WUW-1:0]         s_axis_weights_tuser;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;
    logic                   m_axis_tlast;
    logic [COPIES*PW-1:0]   m_axis_pixels_tdata;
    logic [WW-1:0]          m_axis_weights_tdata;
    logic [WUW+PUW-1:0]     m_axis_tuser;
    logic [CNTW-1:0]        beat_count;
    logic                   err_user_mismatch;

    axis_conv_input_joiner #(
        .COPIES(COPIES), .PIX_WIDTH(PW), .PIX_USER_WIDTH(PUW), .W_WIDTH(WW),
        .W_USER_WIDTH(WUW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CNTW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_pixels_tvalid(s_axis_pixels_tvalid), .s_axis_pixels_tready(s_axis_pixels_tready),
        .s_axis_pixels_tdata(s_axis_pixels_tdata), .s_axis_pixels_tuser(s_axis_pixels_tuser),
        .s_axis_weights_tvalid(s_axis_weights_tvalid), .s_axis_weights_tready(s_axis_weights_tready),
        .s_axis_weights_tlast(s_axis_weights_tlast), .s_axis_weights_tdata(s_axis_weights_tdata),
        .s_axis_weights_tuser(s_axis_weights_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_pixels_tdata(m_axis_pixels_tdata), .m_axis_weights_tdata(m_axis_weights_tdata),
        .m_axis_tuser(m_axis_tuser), .beat_count(beat_count), .err_user_mismatch(err_user_mismatch)
    );

    typedef struct packed { logic [PW-1:0] d; logic [PUW-1:0] u; } pix_t;
    typedef struct packed { logic [WW-1:0] d; logic [WUW-1:0] u; logic l; } wgt_t;

    pix_t pend_p [COPIES][$];
    pix_t mdl_p  [COPIES][$];
    wgt_t pend_w [$];
    wgt_t mdl_w  [$];
    int   pct_p [COPIES];
    int   pct_w;
    int   rdy_mode;
    bit   acc_p [COPIES];
    bit   acc_w;
    int   n_tests;
    int   n_fail;
    int   n_out;
    int   mdl_bc;
    bit   prev_stall;
    logic [COPIES*PW-1:0] prev_pix;
    logic [WW-1:0]        prev_w;
    logic [WUW+PUW-1:0]   prev_user;
    logic                 prev_last;
    logic [CNTW-1:0]      prev_bc;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit busy();
        bit b = m_axis_tvalid || (pend_w.size() != 0) || (mdl_w.size() != 0);
        for (int c = 0; c < COPIES; c++) begin
            if (pend_p[c].size() != 0 || mdl_p[c].size() != 0) b = 1'b1;
        end
        return b;
    endfunction

    // Scoreboard: the k-th output beat is the k-th accepted beat of every input, concatenated.
    task automatic monitor();
        logic [COPIES*PW-1:0] ep;
        bit empty;
        for (int c = 0; c < COPIES; c++) begin
            acc_p[c] = 1'b0;
            if (s_axis_pixels_tvalid[c] && s_axis_pixels_tready[c]) begin
                mdl_p[c].push_back(pend_p[c].pop_front());
                acc_p[c] = 1'b1;
            end
        end
        acc_w = 1'b0;
        if (s_axis_weights_tvalid && s_axis_weights_tready) begin
            mdl_w.push_back(pend_w.pop_front());
            acc_w = 1'b1;
        end
        if (prev_stall) begin
            check("hold_pix", m_axis_pixels_tdata, prev_pix);
            check("hold_w", m_axis_weights_tdata, prev_w);
            check("hold_user", m_axis_tuser, prev_user);
            check("hold_last_valid", {m_axis_tlast, m_axis_tvalid, beat_count}, {prev_last, 1'b1, prev_bc});
        end
        if (!m_axis_tvalid) check("tuser_idle_zero", m_axis_tuser, 0);
        if (m_axis_tvalid && m_axis_tready) begin
            n_out++;
            empty = (mdl_w.size() == 0);
            for (int c = 0; c < COPIES; c++) if (mdl_p[c].size() == 0) empty = 1'b1;
            if (empty) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_beat got=%0h exp=none", m_axis_pixels_tdata);
            end else begin
                for (int c = 0; c < COPIES; c++) ep[c*PW +: PW] = mdl_p[c][0].d;
                check("out_pix", m_axis_pixels_tdata, ep);
                check("out_w", m_axis_weights_tdata, mdl_w[0].d);
                check("out_last", m_axis_tlast, mdl_w[0].l);
                check("out_user", m_axis_tuser, {mdl_w[0].u, mdl_p[0][0].u});
                check("beat_count", beat_count, mdl_bc);
                mdl_bc = mdl_w[0].l ? 0 : mdl_bc + 1;
                for (int c = 0; c < COPIES; c++) void'(mdl_p[c].pop_front());
                void'(mdl_w.pop_front());
            end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_pix   = m_axis_pixels_tdata;
        prev_w     = m_axis_weights_tdata;
        prev_user  = m_axis_tuser;
        prev_last  = m_axis_tlast;
        prev_bc    = beat_count;
    endtask

    task automatic drive();
        for (int c = 0; c < COPIES; c++) begin
            if (!(s_axis_pixels_tvalid[c] && !acc_p[c])) begin
                if (pend_p[c].size() > 0 && $urandom_range(99) < pct_p[c]) begin
                    s_axis_pixels_tvalid[c] = 1'b1;
                    s_axis_pixels_tdata[c*PW +: PW] = pend_p[c][0].d;
                    s_axis_pixels_tuser[c*PUW +: PUW] = pend_p[c][0].u;
                end else begin
                    s_axis_pixels_tvalid[c] = 1'b0;
                end
            end
        end
        if (!(s_axis_weights_tvalid && !acc_w)) begin
            if (pend_w.size() > 0 && $urandom_range(99) < pct_w) begin
                s_axis_weights_tvalid = 1'b1;
                s_axis_weights_tdata  = pend_w[0].d;
                s_axis_weights_tuser  = pend_w[0].u;
                s_axis_weights_tlast  = pend_w[0].l;
            end else begin
                s_axis_weights_tvalid = 1'b0;
            end
        end
        case (rdy_mode)
            0: m_axis_tready = ($urandom_range(1) == 1);
            1: m_axis_tready = 1'b1;
            2: m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'b0;
        endcase
    endtask

    task automatic step();
        @(negedge aclk);
        monitor();
        @(posedge aclk);
        #1;
        drive();
    endtask

    task automatic add_beats(input int n, input int last_mode, input int mism_idx);
        pix_t p;
        wgt_t w;
        logic [PUW-1:0] u;
        for (int i = 0; i < n; i++) begin
            u = PUW'($urandom);
            for (int c = 0; c < COPIES; c++) begin
                p.d = {$urandom, $urandom};
                p.u = u;
                if (i == mism_idx) p.u = (c == 0) ? 8'h04 : 8'h05;
                pend_p[c].push_back(p);
            end
            w.d = {$urandom, $urandom, $urandom, $urandom};
            w.u = WUW'($urandom);
            w.l = (last_mode == 1) ? (i == n - 1) : (last_mode == 2) ? ($urandom_range(4) == 0) : 1'b0;
            pend_w.push_back(w);
        end
    endtask

    task automatic set_pct(input int p);
        for (int c = 0; c < COPIES; c++) pct_p[c] = p;
        pct_w = p;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (busy() && k < 600) begin
            step();
            k++;
        end
        check(tag, busy(), 0);
    endtask

    int n0;
    pix_t dp;
    wgt_t dw;

    initial begin
        n_tests = 0; n_fail = 0; n_out = 0; mdl_bc = 0; prev_stall = 1'b0;
        aresetn = 1'b0;
        s_axis_pixels_tvalid = '0; s_axis_pixels_tdata = '0; s_axis_pixels_tuser = '0;
        s_axis_weights_tvalid = 1'b0; s_axis_weights_tdata = '0; s_axis_weights_tuser = '0;
        s_axis_weights_tlast = 1'b0; m_axis_tready = 1'b0;
        rdy_mode = 1; set_pct(100);

        repeat (2) @(negedge aclk);
        check("rst_pix_tready", s_axis_pixels_tready, 0);
        check("rst_w_tready", s_axis_weights_tready, 0);
        check("rst_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, beat_count, err_user_mismatch}, 0);
        @(posedge aclk); #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        check("rel_pix_tready", s_axis_pixels_tready, {COPIES{1'b1}});
        check("rel_w_tready", s_axis_weights_tready, 1);
        check("rel_tvalid_bc", {m_axis_tvalid, beat_count}, 0);

        // Single directed beat, latency check.
        dp.u = 8'h01; dp.d = 64'h1111_1111_1111_1111; pend_p[0].push_back(dp);
        dp.d = 64'h2222_2222_2222_2222; pend_p[1].push_back(dp);
        dw.d = {4{32'hAAAA_AAAA}}; dw.u = 8'h3C; dw.l = 1'b1; pend_w.push_back(dw);
        m_axis_tready = 1'b1;
        drive();
        step();
        @(negedge aclk); monitor();
        check("lat_edge_n", m_axis_tvalid, 0);
        @(posedge aclk); #1 drive();
        @(negedge aclk); monitor();
        check("lat_edge_n1", m_axis_tvalid, 1);
        check("lat_pix", m_axis_pixels_tdata, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        @(posedge aclk); #1 drive();
        @(negedge aclk); monitor();
        check("single_bc_zero", {m_axis_tvalid, beat_count}, 0);
        @(posedge aclk); #1 drive();

        // Weights stalled: pixels fill to depth and stop.
        n0 = n_out;
        for (int c = 0; c < COPIES; c++) pct_p[c] = 100;
        pct_w = 0;
        add_beats(6, 1, -1);
        repeat (12) step();
        for (int c = 0; c < COPIES; c++) check("stall_accepted", mdl_p[c].size(), DEPTH);
        check("stall_pix_tready", s_axis_pixels_tready, 0);
        check("stall_w_tready", s_axis_weights_tready, 1);
        check("stall_no_out", m_axis_tvalid, 0);
        pct_w = 100;
        drain("stall_drained");
        check("stall_beats_out", n_out - n0, 6);

        // Streaming with alternating ready.
        n0 = n_out; rdy_mode = 2; set_pct(100);
        add_beats(16, 1, -1);
        drain("stream_drained");
        check("stream_beats_out", n_out - n0, 16);
        check("stream_bc_end", beat_count, 0);

        // Random rounds.
        for (int r = 0; r < 4; r++) begin
            rdy_mode = 0;
            for (int c = 0; c < COPIES; c++) pct_p[c] = $urandom_range(100, 20);
            pct_w = $urandom_range(100, 20);
            add_beats(30, 2, -1);
            drain("random_drained");
        end

        // Copy-user mismatch on beat 3.
        rdy_mode = 1; set_pct(100);
        check("err_before", err_user_mismatch, 0);
        add_beats(5, 1, 2);
        drain("mism_drained");
        check("err_after", err_user_mismatch, USER_CHK);
        add_beats(3, 1, -1);
        drain("mism2_drained");
        check("err_sticky", err_user_mismatch, USER_CHK);

        // Reset while beats are buffered.
        rdy_mode = 3; set_pct(100);
        add_beats(3, 0, -1);
        repeat (8) step();
        check("pre_rst_buffered", mdl_w.size(), 3);
        #3 aresetn = 1'b0;
        #1;
        check("arst_tvalid_last", {m_axis_tvalid, m_axis_tlast}, 0);
        check("arst_user_bc", {m_axis_tuser, beat_count}, 0);
        check("arst_data", {m_axis_pixels_tdata, m_axis_weights_tdata}, 0);
        check("arst_tready", {s_axis_pixels_tready, s_axis_weights_tready}, 0);
        check("arst_err", err_user_mismatch, 0);
        for (int c = 0; c < COPIES; c++) begin pend_p[c].delete(); mdl_p[c].delete(); end
        pend_w.delete(); mdl_w.delete();
        s_axis_pixels_tvalid = '0; s_axis_weights_tvalid = 1'b0;
        mdl_bc = 0; prev_stall = 1'b0; rdy_mode = 1; m_axis_tready = 1'b1;
        @(posedge aclk); #1 aresetn = 1'b1;
        n0 = n_out;
        repeat (10) step();
        check("rst_no_stale", n_out - n0, 0);
        check("rst_tready_back", {s_axis_pixels_tready, s_axis_weights_tready}, {(COPIES+1){1'b1}});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
